// File: rtl/rx_byte_fifo.sv
// -----------------------------------------------------------------------------
// rx_byte_fifo
//
// Byte FIFO sitting directly behind the UART receiver. Each single-cycle
// receiver strobe (in_valid + in_data) is captured into a small distributed
// RAM. Bytes are handed to the consumer first-word-fall-through over a
// valid/ready pair. The receiver cannot be stalled, so a byte arriving while
// the FIFO is full (and not being popped) is dropped and accounted for in a
// sticky overflow flag plus a saturating drop counter.
//
// Ports
//   clk               system clock, rising edge
//   i_reset           synchronous active-high reset (pointers, count, flags)
//   in_valid/in_data  receiver byte strobe
//   out_valid         head entry available (occupancy != 0)
//   out_data          head entry, combinational read of storage
//   out_ready         consumer accepts the head entry this cycle
//   o_count           occupancy 0..DEPTH
//   o_full            occupancy == DEPTH
//   o_almost_full     occupancy >= ALMOST_FULL_LEVEL
//   o_overflow        sticky: a byte has been dropped since reset/clear
//   i_clear_overflow  clears o_overflow and o_drop_count
//   o_drop_count      dropped-byte count, saturating at 255
// -----------------------------------------------------------------------------
module rx_byte_fifo #(
  parameter int DW                = 8,
  parameter int DEPTH_LOG2        = 4,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_overflow,
  input  logic                  i_clear_overflow,
  output logic [7:0]            o_drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0]         mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q,   rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]         count_q,    count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic empty, full, push, pop, drop;

  // ---------------------------------------------------------------------------
  // Status flags: decoded from the registered count only, so nothing on the
  // input side reaches out_valid combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DEPTH_C);
  end

  assign out_valid     = !empty;
  assign o_full        = full;
  assign o_almost_full = (count_q >= AF_C);
  assign o_count       = count_q;
  assign o_overflow    = overflow_q;
  assign o_drop_count  = drop_cnt_q;

  // Head of queue straight out of the distributed storage (FWFT).
  assign out_data = mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Handshake decode. A pop in the same cycle frees a slot, so a full FIFO
  // still accepts the incoming byte in that case instead of dropping it.
  // ---------------------------------------------------------------------------
  always_comb begin
    pop  = out_valid && out_ready;
    push = in_valid && (!full || pop);
    drop = in_valid && full && !pop;
  end

  // ---------------------------------------------------------------------------
  // Pointer / occupancy next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Overflow accounting. A drop in the same cycle as a clear wins: the clear
  // discards the old history and this drop becomes the first one counted.
  // ---------------------------------------------------------------------------
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (drop) begin
      overflow_d = 1'b1;
      if (i_clear_overflow)          drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (i_clear_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push && !i_reset) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
module tb_rx_byte_fifo;

  logic       clk;
  logic       i_reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [4:0] o_count;
  logic       o_full;
  logic       o_almost_full;
  logic       o_overflow;
  logic       i_clear_overflow;
  logic [7:0] o_drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of bytes plus the overflow bookkeeping.
  byte unsigned q[$];
  bit           m_ovf;
  int           m_drops;

  rx_byte_fifo #(.DW(8), .DEPTH_LOG2(4), .ALMOST_FULL_LEVEL(12)) dut (
    .clk              (clk),
    .i_reset          (i_reset),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready),
    .o_count          (o_count),
    .o_full           (o_full),
    .o_almost_full    (o_almost_full),
    .o_overflow       (o_overflow),
    .i_clear_overflow (i_clear_overflow),
    .o_drop_count     (o_drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("valid", 32'(out_valid), 32'(q.size() != 0));
    chk("count", 32'(o_count), 32'(q.size()));
    chk("full", 32'(o_full), 32'(q.size() == 16));
    chk("afull", 32'(o_almost_full), 32'(q.size() >= 12));
    chk("ovf", 32'(o_overflow), 32'(m_ovf));
    chk("drops", 32'(o_drop_count), 32'(m_drops));
    if (q.size() != 0) chk("data", 32'(out_data), 32'(q[0]));
  endtask

  // One clock: drive inputs, advance model on the edge, check 1 time unit later.
  task automatic cyc(input bit v, input logic [7:0] d, input bit rdy,
                     input bit clr, input bit rst);
    bit full, pop, drop;
    in_valid = v; in_data = d; out_ready = rdy;
    i_clear_overflow = clr; i_reset = rst;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_ovf = 0; m_drops = 0;
    end else begin
      full = (q.size() == 16);
      pop  = rdy && (q.size() != 0);
      drop = v && full && !pop;
      if (pop) void'(q.pop_front());
      if (v && !drop) q.push_back(d);
      if (drop) begin
        m_ovf   = 1;
        m_drops = clr ? 1 : (m_drops >= 255 ? 255 : m_drops + 1);
      end else if (clr) begin
        m_ovf = 0; m_drops = 0;
      end
    end
    #1;
    in_valid = 0; out_ready = 0; i_clear_overflow = 0; i_reset = 0;
    model_check();
  endtask

  task automatic push(input logic [7:0] d); cyc(1, d, 0, 0, 0); endtask
  task automatic pop1();                   cyc(0, 8'h00, 1, 0, 0); endtask
  task automatic rst1();                   cyc(0, 8'h00, 0, 0, 1); endtask

  initial begin
    in_valid = 0; in_data = 0; out_ready = 0; i_clear_overflow = 0; i_reset = 1;
    m_ovf = 0; m_drops = 0;

    // Reset then a single byte
    rst1();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_drops", 32'(o_drop_count), 32'd0);
    push(8'h41);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", 32'(out_data), 32'h41);
    chk("first_count", 32'(o_count), 32'd1);

    // Ordered drain across wrap
    rst1();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) push(8'(b * 16 + i));
      for (int i = 0; i < 16; i++) begin
        chk("order", 32'(out_data), 32'(b * 16 + i));
        pop1();
      end
    end
    chk("wrap_count", 32'(o_count), 32'd0);

    // Fill, overflow, drain
    rst1();
    for (int i = 0; i < 16; i++) begin
      push(8'(8'hA0 + i));
      chk("af_level", 32'(o_almost_full), 32'(i >= 11));
    end
    chk("full", 32'(o_full), 32'd1);
    push(8'hB0); push(8'hB1);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    chk("drops2", 32'(o_drop_count), 32'd2);
    for (int i = 0; i < 16; i++) begin
      chk("drain_a", 32'(out_data), 32'(8'hA0 + i));
      pop1();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Push and pop together while full
    rst1();
    for (int i = 0; i < 16; i++) push(8'(8'hD0 + i));
    cyc(1, 8'hC0, 1, 0, 0);
    chk("pp_count", 32'(o_count), 32'd16);
    chk("pp_ovf", 32'(o_overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("pp_order", 32'(out_data), (i == 15) ? 32'hC0 : 32'(8'hD1 + i));
      pop1();
    end

    // Clear colliding with a drop
    rst1();
    for (int i = 0; i < 16; i++) push(8'(i));
    for (int i = 0; i < 5; i++) push(8'hEE);
    chk("drops5", 32'(o_drop_count), 32'd5);
    cyc(1, 8'hEF, 0, 1, 0);
    chk("coll_ovf", 32'(o_overflow), 32'd1);
    chk("coll_drops", 32'(o_drop_count), 32'd1);
    cyc(0, 8'h00, 0, 1, 0);
    chk("clr_ovf", 32'(o_overflow), 32'd0);
    chk("clr_drops", 32'(o_drop_count), 32'd0);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) push(8'h99);
    chk("sat", 32'(o_drop_count), 32'd255);

    // Reset with data queued
    rst1();
    for (int i = 0; i < 7; i++) push(8'(8'h30 + i));
    rst1();
    chk("mid_count", 32'(o_count), 32'd0);
    chk("mid_valid", 32'(out_valid), 32'd0);
    push(8'h55);
    chk("mid_first", 32'(out_data), 32'h55);

    // Random traffic: consumer alternates between slow and fast phases so the
    // FIFO swings between empty and full.
    for (int ph = 0; ph < 30; ph++) begin
      int rdy_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 100; i++) begin
        cyc($urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < rdy_pct,
            $urandom_range(99) < 3, $urandom_range(999) < 3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
